mmio_uart_tx: RTL
=================

Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter that consumes the byte the data-memory block emits on a store to the I/O address 0x2000.
- Each store raises a one-cycle `write_strobe` with the byte on `write_data`. The byte is queued in a small FIFO and serialised as 8N1 on `tx`.
- Status outputs feed the load path, so software can poll busy/full before storing.

Parameters:
- CLOCKS_PER_BIT, 868, clock cycles per serial bit (100 MHz / 115200); legal range 2..65535.
- FIFO_DEPTH_LOG2, 3, log2 of FIFO entries (default 8 entries); legal range 1..6.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- write_strobe  input  1  one-cycle pulse: push `write_data` into the FIFO.
- write_data  input  8  byte to transmit.
- tx  output  1  serial line, idle high.
- busy  output  1  high while a frame is on the line or the FIFO is non-empty.
- fifo_full  output  1  high when the FIFO holds 2^FIFO_DEPTH_LOG2 entries.
- fifo_count  output  FIFO_DEPTH_LOG2+1  number of queued bytes, excluding the byte in the shifter.
- overflow_error  output  1  sticky; set when a push arrives while the FIFO is full.

Behaviour:
- Reset (asynchronous, immediate, including mid-frame):
  - tx=1, busy=0, fifo_full=0, fifo_count=0, overflow_error=0.
  - FIFO pointers zeroed, FSM in IDLE, bit counter and baud counter zeroed.
  - Any partial frame is abandoned; the line returns high at once.
- FIFO:
  - Circular buffer with read/write pointers of FIFO_DEPTH_LOG2 bits, wrapping modulo depth.
  - Push: write_strobe=1 and not full → store byte at write pointer, advance pointer. Count is visible +1 after the edge.
  - Push while full → byte dropped, overflow_error set; it clears only on reset. This applies even if a pop happens in the same cycle.
  - Pop occurs only in IDLE when count>0.
  - Simultaneous push and pop with count between 1 and depth-1: both performed, count unchanged.
  - Push into an empty FIFO cannot pop in the same cycle: no write-through.
  - fifo_full = (count == 2^FIFO_DEPTH_LOG2), derived combinationally from the registered count.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If count>0 at an edge: load the head byte into the 8-bit shifter, pop, baud counter=0, go to START.
  - START: tx=0 for exactly CLOCKS_PER_BIT cycles.
    - Baud counter increments each cycle.
    - At count CLOCKS_PER_BIT-1: reset to 0, bit index=0, go to DATA.
  - DATA: tx = shifter[0], LSB first; each bit held CLOCKS_PER_BIT cycles.
    - At the end of each bit period: shift right, bit index+1.
    - After bit index 7 completes: go to STOP.
  - STOP: tx=1 for CLOCKS_PER_BIT cycles, then go to IDLE.
- Frame timing:
  - One frame = 10*CLOCKS_PER_BIT cycles of line time.
  - Back-to-back frames are separated by exactly one IDLE cycle of tx=1.
  - Strobe to start bit: strobe sampled at edge N (FIFO empty, IDLE) → pop at edge N+1 → tx low from edge N+1.
- tx is driven from a register; no combinational glitches.
- busy = (state != IDLE) || (count != 0).
- write_data is sampled only on the cycle write_strobe is high; its value is ignored otherwise.

Test Plan:
- Single byte, CLOCKS_PER_BIT=4, FIFO_DEPTH_LOG2=2:
  - Stimulus: strobe 0xA5 once.
  - Required: tx low 4 cycles starting one edge after the push; then bits 1,0,1,0,0,1,0,1 at 4 cycles each; stop high 4 cycles; busy drops the cycle IDLE is re-entered.
- Burst:
  - Stimulus: strobe 0x01, 0x02, 0x03 on consecutive cycles.
  - Required: fifo_count peaks at 2 (first byte popped); three frames each separated by exactly one idle-high cycle; decoded bytes 0x01, 0x02, 0x03 in order.
- Overflow (depth 4):
  - Stimulus: stall the FSM by keeping a frame in flight, then push 5 bytes 0x10..0x14.
  - Required: fifo_full=1 after the 4th push; the 5th byte is dropped and overflow_error=1. Transmitted sequence is the in-flight byte, then 0x10..0x13; overflow_error stays 1 until reset.
- Pointer wrap:
  - Stimulus: 10 bytes 0x30..0x39 paced so the FIFO never fills.
  - Required: all 10 received in order; fifo_count returns to 0.
- Mid-frame reset:
  - Stimulus: assert reset asynchronously during DATA bit 3 of 0xFF, with 2 bytes queued.
  - Required: tx=1, busy=0, fifo_count=0 immediately, without waiting for a clock edge. After release, a new strobe of 0x5A transmits a clean frame.
- Push/pop coincidence:
  - Stimulus: FIFO holds 1 byte, FSM in IDLE, strobe asserted on the pop cycle.
  - Required: fifo_count stays 1; both bytes are transmitted in order.

Source files
------------

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: byte stores are queued in a circular FIFO
// and shifted out LSB first, with polling status for the load path.
module mmio_uart_tx #(
   parameter int unsigned CLOCKS_PER_BIT  = 868,
   parameter int unsigned FIFO_DEPTH_LOG2 = 3
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     write_strobe,
   input  logic [7:0]               write_data,
   output logic                     tx,
   output logic                     busy,
   output logic                     fifo_full,
   output logic [FIFO_DEPTH_LOG2:0] fifo_count,
   output logic                     overflow_error
);

   localparam int unsigned PW     = FIFO_DEPTH_LOG2;
   localparam int unsigned CW     = FIFO_DEPTH_LOG2 + 1;
   localparam int unsigned DEPTH  = 32'(1) << FIFO_DEPTH_LOG2;
   localparam int unsigned BAUD_W = $clog2(CLOCKS_PER_BIT);

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } state_e;

   logic [7:0]        mem_q [DEPTH];
   logic [PW-1:0]     wr_ptr_q;
   logic [PW-1:0]     rd_ptr_q;
   logic [CW-1:0]     count_q;
   logic [CW-1:0]     count_d;
   state_e            state_q;
   logic [BAUD_W-1:0] baud_q;
   logic [2:0]        bit_q;
   logic [7:0]        shift_q;
   logic              tx_q;
   logic              ovf_q;
   logic              push;
   logic              pop;
   logic              baud_done;

   // A push into a full FIFO is dropped even when a pop frees a slot that cycle.
   always_comb begin
      push      = write_strobe && !fifo_full;
      pop       = (state_q == S_IDLE) && (count_q != '0);
      baud_done = (baud_q == BAUD_W'(CLOCKS_PER_BIT - 1));
      count_d   = count_q;
      if (push && !pop) begin
         count_d = count_q + CW'(1);
      end else if (pop && !push) begin
         count_d = count_q - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= write_data;
      end
   end

   // FIFO bookkeeping and framing FSM; tx_q always carries the level of the next state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         state_q  <= S_IDLE;
         baud_q   <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         tx_q     <= 1'b1;
      end else begin
         count_q <= count_d;
         if (push) begin
            wr_ptr_q <= wr_ptr_q + PW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PW'(1);
         end
         if (write_strobe && fifo_full) begin
            ovf_q <= 1'b1;
         end

         case (state_q)
            S_IDLE: begin
               tx_q <= 1'b1;
               if (pop) begin
                  shift_q <= mem_q[rd_ptr_q];
                  baud_q  <= '0;
                  tx_q    <= 1'b0;
                  state_q <= S_START;
               end
            end
            S_START: begin
               if (baud_done) begin
                  baud_q  <= '0;
                  bit_q   <= '0;
                  tx_q    <= shift_q[0];
                  state_q <= S_DATA;
               end else begin
                  baud_q <= baud_q + BAUD_W'(1);
               end
            end
            S_DATA: begin
               if (baud_done) begin
                  baud_q  <= '0;
                  shift_q <= shift_q >> 1;
                  bit_q   <= bit_q + 3'd1;
                  if (bit_q == 3'd7) begin
                     tx_q    <= 1'b1;
                     state_q <= S_STOP;
                  end else begin
                     tx_q <= shift_q[1];
                  end
               end else begin
                  baud_q <= baud_q + BAUD_W'(1);
               end
            end
            S_STOP: begin
               tx_q <= 1'b1;
               if (baud_done) begin
                  baud_q  <= '0;
                  state_q <= S_IDLE;
               end else begin
                  baud_q <= baud_q + BAUD_W'(1);
               end
            end
            default: begin
               state_q <= S_IDLE;
               tx_q    <= 1'b1;
            end
         endcase
      end
   end

   assign tx             = tx_q;
   assign busy           = (state_q != S_IDLE) || (count_q != '0);
   assign fifo_full      = (count_q == CW'(DEPTH));
   assign fifo_count     = count_q;
   assign overflow_error = ovf_q;

endmodule
